// File: rtl/alu_exec_if.sv
// ---------------------------------------------------------------------------
// alu_exec_if
// Bus between the issue side, the ALU execute stage and the register file
// write port.
//   Issue side -> stage : in_valid, opcode, op_a, op_b, rd
//   Stage -> issue side : in_ready
//   Stage -> reg file   : reg_write_en, reg_write_dest, reg_write_data
//   Stage status        : flag_z, flag_c, illegal_op
// Modports: master = issue side / observer, slave = execute stage.
// ---------------------------------------------------------------------------
interface alu_exec_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 3,
  parameter int OPC_W  = 4
);
  logic              in_valid;
  logic              in_ready;
  logic [OPC_W-1:0]  opcode;
  logic [DATA_W-1:0] op_a;
  logic [DATA_W-1:0] op_b;
  logic [ADDR_W-1:0] rd;
  logic              reg_write_en;
  logic [ADDR_W-1:0] reg_write_dest;
  logic [DATA_W-1:0] reg_write_data;
  logic              flag_z;
  logic              flag_c;
  logic              illegal_op;

  modport master (
    output in_valid, opcode, op_a, op_b, rd,
    input  in_ready, reg_write_en, reg_write_dest, reg_write_data,
           flag_z, flag_c, illegal_op
  );

  modport slave (
    input  in_valid, opcode, op_a, op_b, rd,
    output in_ready, reg_write_en, reg_write_dest, reg_write_data,
           flag_z, flag_c, illegal_op
  );
endinterface

// File: rtl/alu_exec_stage.sv
// ---------------------------------------------------------------------------
// alu_exec_stage
// Execute stage feeding the register file write port. Single-cycle ops are
// written back one cycle after acceptance; MUL is an iterative shift-add
// multiply (DATA_W iterations) that holds in_ready low until write-back.
// Ports:
//   clk   - rising-edge clock
//   rst_n - synchronous active-low reset
//   bus   - alu_exec_if.slave: issue handshake/operands in, write port and
//           flags out (all outputs registered, in_ready decoded from state)
// ---------------------------------------------------------------------------
module alu_exec_stage #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 3,
  parameter int OPC_W  = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  alu_exec_if.slave  bus
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_MUL_RUN = 2'd1;
  localparam logic [1:0] S_MUL_WB  = 2'd2;

  localparam int SH_W  = $clog2(DATA_W);
  localparam int CNT_W = $clog2(DATA_W + 1);

  localparam logic [OPC_W-1:0] OP_NOP = OPC_W'(0);
  localparam logic [OPC_W-1:0] OP_ADD = OPC_W'(1);
  localparam logic [OPC_W-1:0] OP_SUB = OPC_W'(2);
  localparam logic [OPC_W-1:0] OP_AND = OPC_W'(3);
  localparam logic [OPC_W-1:0] OP_OR  = OPC_W'(4);
  localparam logic [OPC_W-1:0] OP_XOR = OPC_W'(5);
  localparam logic [OPC_W-1:0] OP_SHL = OPC_W'(6);
  localparam logic [OPC_W-1:0] OP_SHR = OPC_W'(7);
  localparam logic [OPC_W-1:0] OP_MUL = OPC_W'(8);
  localparam logic [OPC_W-1:0] OP_CMP = OPC_W'(9);

  logic [1:0]          r_state;
  logic [CNT_W-1:0]    r_cnt;
  logic [2*DATA_W-1:0] r_mcand;
  logic [DATA_W-1:0]   r_mplier;
  logic [2*DATA_W-1:0] r_acc;
  logic [ADDR_W-1:0]   r_mul_rd;
  logic                r_we;
  logic [ADDR_W-1:0]   r_dest;
  logic [DATA_W-1:0]   r_data;
  logic                r_z;
  logic                r_c;
  logic                r_ill;

  logic                w_accept;
  logic [SH_W-1:0]     w_shamt;
  logic [DATA_W:0]     w_shl;
  logic [DATA_W:0]     w_shr;
  logic [DATA_W-1:0]   w_res;
  logic                w_c;
  logic                w_wr;
  logic                w_upd;
  logic                w_ill;

  assign w_accept = bus.in_valid && (r_state == S_IDLE);
  assign w_shamt  = bus.op_b[SH_W-1:0];

  // One guard bit on the side bits leave from: it ends up holding the last
  // bit shifted out, and stays 0 for a zero shift amount.
  assign w_shl = {1'b0, bus.op_a} << w_shamt;
  assign w_shr = {bus.op_a, 1'b0} >> w_shamt;

  // Single-cycle result, carry and write/flag-update/illegal decode.
  always_comb begin
    w_res = '0;
    w_c   = 1'b0;
    w_wr  = 1'b0;
    w_upd = 1'b0;
    w_ill = 1'b0;
    case (bus.opcode)
      OP_NOP: ;
      OP_ADD: begin
        {w_c, w_res} = {1'b0, bus.op_a} + {1'b0, bus.op_b};
        w_wr = 1'b1; w_upd = 1'b1;
      end
      OP_SUB: begin
        w_res = bus.op_a - bus.op_b;
        w_c   = (bus.op_a < bus.op_b);
        w_wr  = 1'b1; w_upd = 1'b1;
      end
      OP_CMP: begin
        w_res = bus.op_a - bus.op_b;
        w_c   = (bus.op_a < bus.op_b);
        w_upd = 1'b1;
      end
      OP_AND: begin w_res = bus.op_a & bus.op_b; w_wr = 1'b1; w_upd = 1'b1; end
      OP_OR:  begin w_res = bus.op_a | bus.op_b; w_wr = 1'b1; w_upd = 1'b1; end
      OP_XOR: begin w_res = bus.op_a ^ bus.op_b; w_wr = 1'b1; w_upd = 1'b1; end
      OP_SHL: begin
        w_res = w_shl[DATA_W-1:0];
        w_c   = w_shl[DATA_W];
        w_wr  = 1'b1; w_upd = 1'b1;
      end
      OP_SHR: begin
        w_res = w_shr[DATA_W:1];
        w_c   = w_shr[0];
        w_wr  = 1'b1; w_upd = 1'b1;
      end
      OP_MUL: ;  // handled by the FSM
      default: w_ill = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_acc    <= '0;
      r_mul_rd <= '0;
      r_we     <= 1'b0;
      r_dest   <= '0;
      r_data   <= '0;
      r_z      <= 1'b0;
      r_c      <= 1'b0;
      r_ill    <= 1'b0;
    end else begin
      r_we  <= 1'b0;
      r_ill <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            if (bus.opcode == OP_MUL) begin
              r_mcand  <= {{DATA_W{1'b0}}, bus.op_a};
              r_mplier <= bus.op_b;
              r_mul_rd <= bus.rd;
              r_acc    <= '0;
              r_cnt    <= '0;
              r_state  <= S_MUL_RUN;
            end else begin
              if (w_wr) begin
                r_we   <= 1'b1;
                r_dest <= bus.rd;
                r_data <= w_res;
              end
              if (w_upd) begin
                r_z <= (w_res == '0);
                r_c <= w_c;
              end
              r_ill <= w_ill;
            end
          end
        end
        S_MUL_RUN: begin
          if (r_mplier[0]) r_acc <= r_acc + r_mcand;
          r_mcand  <= r_mcand << 1;
          r_mplier <= r_mplier >> 1;
          r_cnt    <= r_cnt + CNT_W'(1);
          if (r_cnt == CNT_W'(DATA_W - 1)) r_state <= S_MUL_WB;
        end
        S_MUL_WB: begin
          r_we    <= 1'b1;
          r_dest  <= r_mul_rd;
          r_data  <= r_acc[DATA_W-1:0];
          r_z     <= (r_acc[DATA_W-1:0] == '0);
          r_c     <= |r_acc[2*DATA_W-1:DATA_W];
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.in_ready       = (r_state == S_IDLE);
  assign bus.reg_write_en   = r_we;
  assign bus.reg_write_dest = r_dest;
  assign bus.reg_write_data = r_data;
  assign bus.flag_z         = r_z;
  assign bus.flag_c         = r_c;
  assign bus.illegal_op     = r_ill;

endmodule

// File: tb/tb_alu_exec_stage.sv
module tb_alu_exec_stage;

  localparam int DATA_W = 8;
  localparam int ADDR_W = 3;
  localparam int OPC_W  = 4;

  logic clk;
  logic rst_n;
  int   n_total;
  int   n_pass;

  alu_exec_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .OPC_W(OPC_W)) bus ();

  alu_exec_stage #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .OPC_W(OPC_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "simulation time limit reached");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  // Present one instruction at a negedge, let it transfer at the posedge,
  // return at the following negedge with in_valid dropped.
  task automatic issue(input logic [3:0] op, input logic [7:0] a,
                       input logic [7:0] b, input logic [2:0] rd);
    bus.in_valid = 1'b1;
    bus.opcode   = op;
    bus.op_a     = a;
    bus.op_b     = b;
    bus.rd       = rd;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  task automatic wb(input string tag, input logic [2:0] dest, input logic [7:0] data,
                    input logic z, input logic c);
    chk({tag, "_we"},   32'(bus.reg_write_en),   32'd1);
    chk({tag, "_dest"}, 32'(bus.reg_write_dest), 32'(dest));
    chk({tag, "_data"}, 32'(bus.reg_write_data), 32'(data));
    chk({tag, "_z"},    32'(bus.flag_z),         32'(z));
    chk({tag, "_c"},    32'(bus.flag_c),         32'(c));
  endtask

  task automatic mul_run(input string tag, input logic [7:0] a, input logic [7:0] b,
                         input logic [2:0] rd, input logic [7:0] data,
                         input logic z, input logic c);
    int cnt;
    int early;
    cnt   = 0;
    early = 0;
    issue(4'd8, a, b, rd);
    while (bus.in_ready !== 1'b1 && cnt < 20) begin
      cnt++;
      if (bus.reg_write_en === 1'b1) early++;
      @(negedge clk);
    end
    chk({tag, "_stall_cycles"}, 32'(cnt), 32'd9);
    chk({tag, "_early_write"},  32'(early), 32'd0);
    wb(tag, rd, data, z, c);
  endtask

  initial begin
    int wr_seen;
    n_total = 0;
    n_pass  = 0;

    // Reset held two clocks while an ADD is offered
    rst_n        = 1'b0;
    bus.in_valid = 1'b1;
    bus.opcode   = 4'd1;
    bus.op_a     = 8'h01;
    bus.op_b     = 8'h01;
    bus.rd       = 3'd2;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_we",      32'(bus.reg_write_en),   32'd0);
    chk("rst_dest",    32'(bus.reg_write_dest), 32'd0);
    chk("rst_data",    32'(bus.reg_write_data), 32'd0);
    chk("rst_z",       32'(bus.flag_z),         32'd0);
    chk("rst_c",       32'(bus.flag_c),         32'd0);
    chk("rst_illegal", 32'(bus.illegal_op),     32'd0);
    rst_n        = 1'b1;
    bus.in_valid = 1'b0;
    chk("rst_ready", 32'(bus.in_ready), 32'd1);
    @(negedge clk);
    chk("idle_no_we", 32'(bus.reg_write_en), 32'd0);

    // ADD with carry, then SUB back-to-back
    issue(4'd1, 8'hF0, 8'h20, 3'd3);
    wb("add", 3'd3, 8'h10, 1'b0, 1'b1);
    issue(4'd2, 8'h05, 8'h05, 3'd1);
    wb("sub", 3'd1, 8'h00, 1'b1, 1'b0);
    @(negedge clk);
    chk("hold_we",   32'(bus.reg_write_en),   32'd0);
    chk("hold_dest", 32'(bus.reg_write_dest), 32'd1);
    chk("hold_data", 32'(bus.reg_write_data), 32'h00);

    // Logic op and shifts
    issue(4'd5, 8'hFF, 8'h0F, 3'd0);
    wb("xor", 3'd0, 8'hF0, 1'b0, 1'b0);
    issue(4'd6, 8'h81, 8'h01, 3'd2);
    wb("shl1", 3'd2, 8'h02, 1'b0, 1'b1);
    issue(4'd7, 8'h01, 8'h01, 3'd2);
    wb("shr1", 3'd2, 8'h00, 1'b1, 1'b1);
    issue(4'd6, 8'h5A, 8'h08, 3'd6);
    wb("shl0", 3'd6, 8'h5A, 1'b0, 1'b0);
    issue(4'd7, 8'hB4, 8'h03, 3'd6);
    wb("shr3", 3'd6, 8'h16, 1'b0, 1'b1);

    // Iterative multiplies, the second issued as soon as ready returns
    mul_run("mul_a", 8'h0D, 8'h0B, 3'd5, 8'h8F, 1'b0, 1'b0);
    mul_run("mul_b", 8'h10, 8'h10, 3'd4, 8'h00, 1'b1, 1'b1);
    @(negedge clk);
    chk("mul_single_we", 32'(bus.reg_write_en), 32'd0);

    // CMP updates flags only; illegal opcode pulses and leaves flags alone
    issue(4'd9, 8'h03, 8'h07, 3'd6);
    chk("cmp_we",   32'(bus.reg_write_en),   32'd0);
    chk("cmp_c",    32'(bus.flag_c),         32'd1);
    chk("cmp_z",    32'(bus.flag_z),         32'd0);
    chk("cmp_dest", 32'(bus.reg_write_dest), 32'd4);
    issue(4'd12, 8'h00, 8'h00, 3'd1);
    chk("ill_pulse", 32'(bus.illegal_op),   32'd1);
    chk("ill_we",    32'(bus.reg_write_en), 32'd0);
    chk("ill_c",     32'(bus.flag_c),       32'd1);
    chk("ill_z",     32'(bus.flag_z),       32'd0);
    @(negedge clk);
    chk("ill_once", 32'(bus.illegal_op), 32'd0);
    issue(4'd0, 8'h12, 8'h34, 3'd2);
    chk("nop_we", 32'(bus.reg_write_en), 32'd0);

    // Reset in the middle of a multiply aborts it
    issue(4'd8, 8'h03, 8'h03, 3'd7);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("abort_ready", 32'(bus.in_ready),       32'd1);
    chk("abort_data",  32'(bus.reg_write_data), 32'd0);
    wr_seen = 0;
    for (int i = 0; i < 12; i++) begin
      if (bus.reg_write_en === 1'b1) wr_seen++;
      @(negedge clk);
    end
    chk("abort_no_wb", 32'(wr_seen), 32'd0);
    issue(4'd1, 8'h01, 8'h01, 3'd0);
    wb("post_abort_add", 3'd0, 8'h02, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
